// File: rtl/seletor_alvo_if.sv
// Control-unit <-> target-selector bundle: request/candidate inputs and the
// selection result going back to the action datapath.
interface seletor_alvo_if #(
  parameter int N_JOG = 5,
  parameter int W_JOG = 3
);
  logic             pedir_escolha;
  logic [W_JOG-1:0] jogador_atual;
  logic             proibe_atual;
  logic [N_JOG-1:0] mortes;
  logic             botao_prox;
  logic             botao_confirma;
  logic [W_JOG-1:0] jogador_escolhido;
  logic             escolha_pronta;
  logic             escolha_timeout;
  logic             sem_alvo;
  logic             ocupado;
  logic [1:0]       db_estado;

  modport master (
    output pedir_escolha, jogador_atual, proibe_atual, mortes, botao_prox, botao_confirma,
    input  jogador_escolhido, escolha_pronta, escolha_timeout, sem_alvo, ocupado, db_estado
  );

  modport slave (
    input  pedir_escolha, jogador_atual, proibe_atual, mortes, botao_prox, botao_confirma,
    output jogador_escolhido, escolha_pronta, escolha_timeout, sem_alvo, ocupado, db_estado
  );
endinterface

// File: rtl/seletor_alvo.sv
// Target selector: walks living candidates on "next", completes on "confirm",
// on timeout, or when no valid candidate exists.
module seletor_alvo #(
  parameter int N_JOG   = 5,
  parameter int W_JOG   = 3,
  parameter int TIMEOUT = 1000,
  parameter int W_TO    = 10
) (
  input  logic         clock,
  input  logic         rst_global_n,
  seletor_alvo_if.slave bus
);
  localparam int W_PR = $clog2(N_JOG + 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    BUSCA  = 2'b01,
    ESPERA = 2'b10,
    FIM    = 2'b11
  } estado_t;

  estado_t          r_estado, w_estado;
  logic [W_JOG-1:0] r_cand, w_cand, w_cand_inc;
  logic [W_PR-1:0]  r_probes, w_probes;
  logic [W_TO-1:0]  r_to, w_to;
  logic             r_prox_ant, r_conf_ant;
  logic             r_flag_to, r_flag_sa, w_flag_to, w_flag_sa;
  logic             w_ed_prox, w_ed_conf, w_valido;

  // Edge history runs in every state so a button held on entry to ESPERA is not an edge.
  assign w_ed_prox  = bus.botao_prox & ~r_prox_ant;
  assign w_ed_conf  = bus.botao_confirma & ~r_conf_ant;
  assign w_valido   = !bus.mortes[r_cand] && !(bus.proibe_atual && (r_cand == bus.jogador_atual));
  assign w_cand_inc = (r_cand == W_JOG'(N_JOG - 1)) ? '0 : r_cand + 1'b1;

  always_ff @(posedge clock or negedge rst_global_n) begin
    if (!rst_global_n) begin
      r_estado   <= OCIOSO;
      r_cand     <= '0;
      r_probes   <= '0;
      r_to       <= '0;
      r_prox_ant <= 1'b0;
      r_conf_ant <= 1'b0;
      r_flag_to  <= 1'b0;
      r_flag_sa  <= 1'b0;
    end else begin
      r_estado   <= w_estado;
      r_cand     <= w_cand;
      r_probes   <= w_probes;
      r_to       <= w_to;
      r_prox_ant <= bus.botao_prox;
      r_conf_ant <= bus.botao_confirma;
      r_flag_to  <= w_flag_to;
      r_flag_sa  <= w_flag_sa;
    end
  end

  always_comb begin
    w_estado  = r_estado;
    w_cand    = r_cand;
    w_probes  = r_probes;
    w_to      = r_to;
    w_flag_to = r_flag_to;
    w_flag_sa = r_flag_sa;
    case (r_estado)
      OCIOSO: begin
        if (bus.pedir_escolha) begin
          w_cand   = '0;
          w_probes = '0;
          w_estado = BUSCA;
        end
      end
      BUSCA: begin
        // A full lap of misses means nobody is targetable.
        if (r_probes == W_PR'(N_JOG)) begin
          w_flag_sa = 1'b1;
          w_estado  = FIM;
        end else if (w_valido) begin
          w_to     = '0;
          w_estado = ESPERA;
        end else begin
          w_cand   = w_cand_inc;
          w_probes = r_probes + 1'b1;
        end
      end
      ESPERA: begin
        if (w_ed_conf) begin
          w_estado = FIM;
        end else if (w_ed_prox) begin
          w_cand   = w_cand_inc;
          w_probes = '0;
          w_estado = BUSCA;
        end else if (!w_valido) begin
          w_probes = '0;
          w_estado = BUSCA;
        end else if (r_to == W_TO'(TIMEOUT - 1)) begin
          w_flag_to = 1'b1;
          w_estado  = FIM;
        end else begin
          w_to = r_to + 1'b1;
        end
      end
      FIM: begin
        w_flag_to = 1'b0;
        w_flag_sa = 1'b0;
        w_estado  = OCIOSO;
      end
      default: w_estado = OCIOSO;
    endcase
  end

  assign bus.jogador_escolhido = r_cand;
  assign bus.escolha_pronta    = (r_estado == FIM);
  assign bus.escolha_timeout   = r_flag_to;
  assign bus.sem_alvo          = r_flag_sa;
  assign bus.ocupado           = (r_estado != OCIOSO);
  assign bus.db_estado         = r_estado;
endmodule
